// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file geometry, PC index and write-back source encoding.
// Reused by decode, the register file and the write-back scheduler.
package cpu_pkg;

    localparam int unsigned NREG = 16;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = $clog2(NREG);

    localparam logic [AW-1:0] REG_PC = 4'd15;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

    // ldrb data: low byte, zero-extended to the full data width
    function automatic logic [DW-1:0] zext_byte(input logic [DW-1:0] d);
        return {{(DW - 8){1'b0}}, d[7:0]};
    endfunction

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Handshake bundle between execute/memory, decode and the write-back scheduler.
// The scheduler takes the slave side; producers and the register file take the master side.
interface regfile_wb_sched_if #(
    parameter int unsigned NREG = 16,
    parameter int unsigned DW   = 32
);
    localparam int unsigned AW = $clog2(NREG);

    logic            alu_valid;
    logic [AW-1:0]   alu_wa;
    logic [DW-1:0]   alu_wd;
    logic            alu_ready;

    logic            mem_valid;
    logic [AW-1:0]   mem_wa;
    logic [DW-1:0]   mem_wd;
    logic            mem_byte;
    logic            mem_ready;

    logic            issue_valid;
    logic [AW-1:0]   issue_wa;
    logic            issue_ready;

    logic            we;
    logic [AW-1:0]   wa;
    logic [DW-1:0]   wd;
    logic [NREG-1:0] busy;
    logic            err;

    modport slave (
        input  alu_valid, alu_wa, alu_wd,
        output alu_ready,
        input  mem_valid, mem_wa, mem_wd, mem_byte,
        output mem_ready,
        input  issue_valid, issue_wa,
        output issue_ready,
        output we, wa, wd, busy, err
    );

    modport master (
        output alu_valid, alu_wa, alu_wd,
        input  alu_ready,
        output mem_valid, mem_wa, mem_wd, mem_byte,
        input  mem_ready,
        output issue_valid, issue_wa,
        input  issue_ready,
        input  we, wa, wd, busy, err
    );

endinterface

// File: rtl/regfile_wb_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer remembers the last granted requester
// and only moves when the caller signals that the grant was actually taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    logic last_q, last_d;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (adv) begin
            last_d = gnt[1];
        end
    end

    // Reset to "last = 1" so requester 0 wins the first conflict
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: arbitrates ALU and load results onto the register-file write port
// and tracks outstanding destinations in a busy scoreboard.
module regfile_wb_sched
    import cpu_pkg::*;
#(
    parameter int unsigned NREG = cpu_pkg::NREG,
    parameter int unsigned DW   = cpu_pkg::DW
) (
    input logic               clk,
    input logic               reset,
    regfile_wb_sched_if.slave bus
);

    localparam int unsigned RegAw = $clog2(NREG);

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             xfer;
    logic             issue_xfer;
    wb_src_e          src;

    logic             we_q, we_d;
    logic [RegAw-1:0] wa_q, wa_d;
    logic [DW-1:0]    wd_q, wd_d;
    logic [NREG-1:0]  busy_q, busy_d;
    logic             err_q, err_d;

    assign req = {bus.mem_valid, bus.alu_valid};

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .adv   (xfer),
        .gnt   (gnt)
    );

    assign bus.alu_ready = gnt[0] & ~reset;
    assign bus.mem_ready = gnt[1] & ~reset;
    assign xfer          = (bus.alu_valid & bus.alu_ready) | (bus.mem_valid & bus.mem_ready);
    assign src           = gnt[1] ? WB_MEM : WB_ALU;

    // A register whose write lands this cycle may be re-issued immediately
    assign bus.issue_ready = ~reset &
                             (~busy_q[bus.issue_wa] | (we_q & (wa_q == bus.issue_wa)));
    assign issue_xfer      = bus.issue_valid & bus.issue_ready;

    always_comb begin
        we_d = xfer;
        wa_d = wa_q;
        wd_d = wd_q;
        if (xfer) begin
            unique case (src)
                WB_ALU: begin
                    wa_d = bus.alu_wa;
                    wd_d = bus.alu_wd;
                end
                WB_MEM: begin
                    wa_d = bus.mem_wa;
                    wd_d = bus.mem_byte ? zext_byte(bus.mem_wd) : bus.mem_wd;
                end
            endcase
        end
    end

    // Clear before set so an issue on the retiring register keeps it busy
    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        if (we_q) begin
            busy_d[wa_q] = 1'b0;
            if (!busy_q[wa_q]) begin
                err_d = 1'b1;
            end
        end
        if (issue_xfer) begin
            busy_d[bus.issue_wa] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            we_q   <= we_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign bus.we   = we_q;
    assign bus.wa   = wa_q;
    assign bus.wd   = wd_q;
    assign bus.busy = busy_q;
    assign bus.err  = err_q;

endmodule
